// File: rtl/ex_wb_stage_buf.sv
// rtl/ex_wb_stage_buf.sv - execute to write-back stage register built as a 2-entry skid buffer
//
// Purpose:
//   Holds execute results (wdata, we, rd index) between the R-type execute unit
//   and the register-file write-back port. The main entry drives the outputs and
//   the skid entry absorbs one extra result under back-pressure, so ex_ready_out
//   is a registered signal with no combinational path from wb_ready_in.
//
// Ports:
//   clk_in, reset_in (async, active-high), flush_in (sync kill of held entries)
//   ex_valid_in / ex_ready_out / reg_wdata_in / reg_we_in / reg_waddr_in  : execute side
//   wb_valid_out / wb_ready_in / reg_wdata_out / reg_we_out / reg_waddr_out : write-back side
//
// Optional feature (macro EX_WB_FWD_EN):
//   fwd_rs1_in, fwd_rs2_in            : operand indices to look up
//   fwd_rs1_hit_out, fwd_rs1_data_out : combinational forwarding result for rs1
//   fwd_rs2_hit_out, fwd_rs2_data_out : combinational forwarding result for rs2
module ex_wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              flush_in,
  input  logic              ex_valid_in,
  output logic              ex_ready_out,
  input  logic [DATA_W-1:0] reg_wdata_in,
  input  logic              reg_we_in,
  input  logic [ADDR_W-1:0] reg_waddr_in,
  output logic              wb_valid_out,
  input  logic              wb_ready_in,
  output logic [DATA_W-1:0] reg_wdata_out,
  output logic              reg_we_out,
`ifdef EX_WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_rs1_in,
  input  logic [ADDR_W-1:0] fwd_rs2_in,
  output logic              fwd_rs1_hit_out,
  output logic [DATA_W-1:0] fwd_rs1_data_out,
  output logic              fwd_rs2_hit_out,
  output logic [DATA_W-1:0] fwd_rs2_data_out,
`endif
  output logic [ADDR_W-1:0] reg_waddr_out
);

  logic              main_v_q, main_v_d;
  logic              main_we_q, main_we_d;
  logic [DATA_W-1:0] main_wdata_q, main_wdata_d;
  logic [ADDR_W-1:0] main_waddr_q, main_waddr_d;
  logic              skid_v_q, skid_v_d;
  logic              skid_we_q, skid_we_d;
  logic [DATA_W-1:0] skid_wdata_q, skid_wdata_d;
  logic [ADDR_W-1:0] skid_waddr_q, skid_waddr_d;
  logic              ready_q, ready_d;

  logic              accept;
  logic              consume;
  logic              in_is_x0;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata;

  assign accept  = ex_valid_in & ready_q;
  assign consume = main_v_q & wb_ready_in;

  // Writes to x0 are neutralised at capture: the slot is still used so ordering
  // and occupancy are unaffected, but nothing reaches the register file.
  assign in_is_x0  = (reg_waddr_in == '0);
  assign cap_we    = reg_we_in & ~in_is_x0;
  assign cap_wdata = in_is_x0 ? '0 : reg_wdata_in;

  always_comb begin
    main_v_d     = main_v_q;
    main_we_d    = main_we_q;
    main_wdata_d = main_wdata_q;
    main_waddr_d = main_waddr_q;
    skid_v_d     = skid_v_q;
    skid_we_d    = skid_we_q;
    skid_wdata_d = skid_wdata_q;
    skid_waddr_d = skid_waddr_q;
    ready_d      = ready_q;

    if (flush_in) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      ready_d  = 1'b1;
    end else if (!main_v_q || (!skid_v_q && consume)) begin
      // Main slot is free or being vacated: the new result goes straight to main.
      main_v_d = accept;
      if (accept) begin
        main_we_d    = cap_we;
        main_wdata_d = cap_wdata;
        main_waddr_d = reg_waddr_in;
      end
    end else if (!skid_v_q) begin
      // Main is stalled: park the younger result in skid and stop accepting.
      if (accept) begin
        skid_v_d     = 1'b1;
        skid_we_d    = cap_we;
        skid_wdata_d = cap_wdata;
        skid_waddr_d = reg_waddr_in;
        ready_d      = 1'b0;
      end
    end else if (consume) begin
      // Both full and main drains: skid moves up, accepting resumes next cycle.
      main_we_d    = skid_we_q;
      main_wdata_d = skid_wdata_q;
      main_waddr_d = skid_waddr_q;
      skid_v_d     = 1'b0;
      ready_d      = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      main_v_q     <= 1'b0;
      main_we_q    <= 1'b0;
      main_wdata_q <= '0;
      main_waddr_q <= '0;
      skid_v_q     <= 1'b0;
      skid_we_q    <= 1'b0;
      skid_wdata_q <= '0;
      skid_waddr_q <= '0;
      ready_q      <= 1'b1;
    end else begin
      main_v_q     <= main_v_d;
      main_we_q    <= main_we_d;
      main_wdata_q <= main_wdata_d;
      main_waddr_q <= main_waddr_d;
      skid_v_q     <= skid_v_d;
      skid_we_q    <= skid_we_d;
      skid_wdata_q <= skid_wdata_d;
      skid_waddr_q <= skid_waddr_d;
      ready_q      <= ready_d;
    end
  end

  assign ex_ready_out  = ready_q;
  assign wb_valid_out  = main_v_q;
  assign reg_we_out    = main_v_q & main_we_q;
  assign reg_wdata_out = main_wdata_q;
  assign reg_waddr_out = main_waddr_q;

`ifdef EX_WB_FWD_EN
  logic main_hit1, skid_hit1, main_hit2, skid_hit2;

  // The skid entry is younger, so it takes priority over main on a double hit.
  // A stored we=1 already implies a non-zero index, so rs == 0 cannot hit.
  assign main_hit1 = main_v_q & main_we_q & (main_waddr_q == fwd_rs1_in) & (fwd_rs1_in != '0);
  assign skid_hit1 = skid_v_q & skid_we_q & (skid_waddr_q == fwd_rs1_in) & (fwd_rs1_in != '0);
  assign main_hit2 = main_v_q & main_we_q & (main_waddr_q == fwd_rs2_in) & (fwd_rs2_in != '0);
  assign skid_hit2 = skid_v_q & skid_we_q & (skid_waddr_q == fwd_rs2_in) & (fwd_rs2_in != '0);

  assign fwd_rs1_hit_out  = main_hit1 | skid_hit1;
  assign fwd_rs1_data_out = skid_hit1 ? skid_wdata_q : (main_hit1 ? main_wdata_q : '0);
  assign fwd_rs2_hit_out  = main_hit2 | skid_hit2;
  assign fwd_rs2_data_out = skid_hit2 ? skid_wdata_q : (main_hit2 ? main_wdata_q : '0);
`endif

endmodule
